// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage: access-size encodings,
// FSM state type, wait counter width and the alignment check helper.
package dmem_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // True when the access size cannot be served at this byte offset.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data-memory stage: merges store data into the
// addressed lanes of a word, and extracts/extends load data from a word.
// size must already be legal-or-word here; unknown sizes act as word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  output logic [31:0] new_word,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Store merge: overwrite only the addressed lanes of the old word.
  always_comb begin
    new_word = word;
    case (size)
      SZ_BYTE: new_word[{lane, 3'b000} +: 8]        = wdata[7:0];
      SZ_HALF: new_word[{lane[1], 4'b0000} +: 16]   = wdata[15:0];
      default: new_word                             = wdata;
    endcase
  end

  // Load extract: pick the addressed lane and extend to 32 bits.
  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
      SZ_HALF: load_data = {{16{sign_ext & half_v[15]}}, half_v};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/dmem_stage.sv
// Data-memory stage: word-organised RAM behind a valid/ready request with a
// fixed number of wait states, a one-cycle response pulse and a stall output.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned or illegal-size requests
// fault instead of being force-aligned.
module dmem_stage
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        stall
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               accept, access;

  logic               rd_q, wr_q, sx_q;
  logic [1:0]         size_q, lane_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;

  logic [1:0]         size_eff, lane_eff;
  logic               fault;
  logic [31:0]        rd_word, merged, load_data;

  logic [31:0]        mem [DEPTH_WORDS];

  // Address bits above the RAM index are ignored, so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^addr[31:IDX_W+2];

  assign accept    = (state == ST_IDLE) && req_valid;
  assign access    = (state == ST_WAIT) && (cnt == '0);
  assign req_ready = (state == ST_IDLE);
  assign stall     = accept || (state == ST_WAIT);

  // Resolve size/lane used by the access and whether the request faults.
  always_comb begin
    size_eff = size_q;
    lane_eff = lane_q;
    fault    = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    fault    = is_misaligned(size_q, lane_q);
`else
    if (size_q == SZ_ILL) size_eff = SZ_WORD;
    if (size_eff == SZ_HALF) lane_eff[0] = 1'b0;
    if (size_eff == SZ_WORD) lane_eff = 2'b00;
`endif
  end

  assign rd_word = mem[idx_q];

  dmem_lane_align u_align (
    .word      (rd_word),
    .wdata     (wdata_q),
    .size      (size_eff),
    .lane      (lane_eff),
    .sign_ext  (sx_q),
    .new_word  (merged),
    .load_data (load_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Wait counter and request field capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      sx_q    <= 1'b0;
      size_q  <= '0;
      lane_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt     <= CNT_W'(WAIT_CYCLES);
      rd_q    <= mem_read;
      wr_q    <= mem_write;
      sx_q    <= sign_ext;
      size_q  <= size;
      lane_q  <= addr[1:0];
      idx_q   <= addr[IDX_W+1:2];
      wdata_q <= wdata;
    end else if ((state == ST_WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Registered response, produced by the access cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rdata     <= '0;
      misalign  <= 1'b0;
    end else begin
      rsp_valid <= access;
      if (access) begin
        misalign <= fault;
        rdata    <= (!fault && rd_q && !wr_q) ? load_data : '0;
      end
    end
  end

  // RAM write; gated by rst so a reset during the access cycle drops the store.
  always_ff @(posedge clk) begin
    if (!rst && access && wr_q && !fault) mem[idx_q] <= merged;
  end

endmodule
